// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice built from two half adders
// is reused for WIDTH cycles to form {cout, sum} = op_a + op_b + cin.

module half_adder_dataflow (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;

   logic               ha0_s, ha0_c;
   logic               ha1_s, ha1_c;
   logic               slice_sum, slice_cout;
   logic               last_bit;

   // Shared full-adder slice working on the current LSBs and the running carry.
   half_adder_dataflow u_ha0 (
      .a (a_sr_q[0]),
      .b (b_sr_q[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   half_adder_dataflow u_ha1 (
      .a (ha0_s),
      .b (carry_q),
      .s (ha1_s),
      .c (ha1_c)
   );

   assign slice_sum  = ha1_s;
   assign slice_cout = ha0_c | ha1_c;
   assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE accepts exactly like IDLE so a held start runs back-to-back.
            if (start) begin
               a_sr_d  = op_a;
               b_sr_d  = op_b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            res_d   = {slice_sum, res_q[WIDTH-1:1]};
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = slice_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               sum_d   = res_d;
               cout_d  = slice_cout;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
